// File: rtl/psi_pkg.sv
// Shared definitions for the PSI index stream slice.
// Contents: FSM state type, index-width helper, popcount helper.
// popcount is only referenced when PSI_CARDINALITY_EN is defined.
package psi_pkg;

  typedef enum logic {
    IDLE,
    EMIT
  } psi_state_t;

  // Widest bitmap popcount() supports; W must not exceed this.
  localparam int unsigned PSI_MAXW = 1024;

  function automatic int psi_idxw(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  // Callers zero-extend their bitmap to PSI_MAXW. The constant-zero upper
  // bits fold away in synthesis.
  function automatic int unsigned popcount(input logic [PSI_MAXW-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < PSI_MAXW; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/psi_index_stream_if.sv
// Handshake bundle for psi_index_stream.
// Input side:  in_valid / in_ready / in_bitmap[W-1:0]
// Output side: out_valid / out_ready / out_index[IDXW-1:0] / out_last / out_empty
// slave  : the serializer (accepts bitmaps, produces indices)
// master : the environment (produces bitmaps, consumes indices)
interface psi_index_stream_if
  import psi_pkg::*;
#(
  parameter int W = 10
) ();
  localparam int IDXW = psi_idxw(W);

  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_bitmap;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] out_index;
  logic            out_last;
  logic            out_empty;

  modport slave (
    input  in_valid, in_bitmap, out_ready,
    output in_ready, out_valid, out_index, out_last, out_empty
  );

  modport master (
    output in_valid, in_bitmap, out_ready,
    input  in_ready, out_valid, out_index, out_last, out_empty
  );
endinterface

// File: rtl/psi_lsb_enc.sv
// Combinational lowest-set-bit priority encoder.
// Ports:
//   vector[W-1:0]  input bits
//   idx[IDXW-1:0]  position of lowest set bit (0 when vector == 0)
//   zero           vector == 0
//   single         at most one bit of vector is set
module psi_lsb_enc
  import psi_pkg::*;
#(
  parameter  int W    = 10,
  localparam int IDXW = psi_idxw(W)
) (
  input  logic [W-1:0]    vector,
  output logic [IDXW-1:0] idx,
  output logic            zero,
  output logic            single
);

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!found && vector[i]) begin
        idx   = IDXW'(i);
        found = 1'b1;
      end
    end
  end

  assign zero   = (vector == '0);
  assign single = ((vector & (vector - 1'b1)) == '0);

endmodule

// File: rtl/psi_index_stream.sv
// PSI intersection bitmap serializer: accepts one W-bit bitmap per input
// handshake and emits the index of every set bit in ascending order, one
// per output handshake, flagging the final beat. An empty bitmap yields a
// single beat with out_empty=1.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         psi_index_stream_if.slave (input bitmap / output index stream)
//   card        popcount of last accepted bitmap (only with PSI_CARDINALITY_EN)
// Optional feature macro: PSI_CARDINALITY_EN
module psi_index_stream
  import psi_pkg::*;
#(
  parameter  int W    = 10,
  localparam int IDXW = psi_idxw(W)
) (
  input logic               clk,
  input logic               rst_n,
  psi_index_stream_if.slave bus
`ifdef PSI_CARDINALITY_EN
  ,
  output logic [IDXW:0]     card
`endif
);

  psi_state_t      state_q, state_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [IDXW-1:0] lsb_idx;
  logic            rem_zero;
  logic            rem_single;

  psi_lsb_enc #(.W(W)) u_lsb_enc (
    .vector (rem_q),
    .idx    (lsb_idx),
    .zero   (rem_zero),
    .single (rem_single)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // rem is zero whenever the FSM is idle, so the index outputs already sit
  // at their reset values (index 0, last, empty) outside of EMIT.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_index = lsb_idx;
    bus.out_last  = rem_single;
    bus.out_empty = rem_zero;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          rem_d   = bus.in_bitmap;
          state_d = EMIT;
        end
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          rem_d = rem_q & (rem_q - 1'b1);
          if (rem_single) state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

`ifdef PSI_CARDINALITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      card <= '0;
    end else if (state_q == IDLE && bus.in_valid) begin
      card <= (IDXW+1)'(popcount(PSI_MAXW'(bus.in_bitmap)));
    end
  end
`endif

endmodule

// File: tb/tb_psi_index_stream.sv
// Self-checking bench for psi_index_stream (W=10).
// Reference: each accepted bitmap is expanded into a queue of expected
// indices in ascending order; beats are matched against the queue head.
module tb_psi_index_stream;

  localparam int W    = 10;
  localparam int IDXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  psi_index_stream_if #(.W(W)) bus ();

`ifdef PSI_CARDINALITY_EN
  logic [IDXW:0] card;
  int            exp_card = 0;
`endif

  psi_index_stream #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef PSI_CARDINALITY_EN
    ,
    .card  (card)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 = out_ready always 1, 1 = toggle 1,0,1,0..., 2 = random.
  // During emission in_valid/in_bitmap are driven to nv/nb to show they
  // are ignored until the block returns to idle.
  task automatic run_bitmap(input logic [W-1:0] b, input int mode,
                            input logic [W-1:0] nb, input logic nv);
    int   q[$];
    int   cnt;
    int   beats_left;
    int   budget;
    logic empty;
    logic r;
    q   = {};
    cnt = 0;
    for (int k = 0; k < W; k++) begin
      if (b[k]) begin
        q.push_back(k);
        cnt++;
      end
    end
    empty      = (cnt == 0);
    beats_left = empty ? 1 : cnt;

    check("idle_in_ready", 32'(bus.in_ready), 1);
    check("idle_out_valid", 32'(bus.out_valid), 0);
    bus.in_valid  = 1'b1;
    bus.in_bitmap = b;
    tick;
    bus.in_valid  = nv;
    bus.in_bitmap = nb;
`ifdef PSI_CARDINALITY_EN
    exp_card = cnt;
    check("card_after_accept", 32'(card), 32'(exp_card));
`endif

    budget = 0;
    while (beats_left > 0 && budget < 4 * W + 20) begin
      check("beat_out_valid", 32'(bus.out_valid), 1);
      check("beat_in_ready", 32'(bus.in_ready), 0);
      check("beat_index", 32'(bus.out_index), empty ? 0 : q[0]);
      check("beat_last", 32'(bus.out_last), (beats_left == 1) ? 1 : 0);
      check("beat_empty", 32'(bus.out_empty), 32'(empty));
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = (budget % 2 == 0);
      else                r = 1'($urandom_range(0, 1));
      bus.out_ready = r;
      tick;
      budget++;
      if (r) begin
        beats_left--;
        if (!empty) void'(q.pop_front());
      end
    end
    if (beats_left > 0) check("emit_timeout", 32'(beats_left), 0);

    check("post_out_valid", 32'(bus.out_valid), 0);
    check("post_in_ready", 32'(bus.in_ready), 1);
`ifdef PSI_CARDINALITY_EN
    check("card_hold", 32'(card), 32'(exp_card));
`endif
  endtask

  initial begin
    logic [W-1:0] rb;
    logic [W-1:0] rnb;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bitmap = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_last", 32'(bus.out_last), 1);
    check("rst_out_empty", 32'(bus.out_empty), 1);
    check("rst_out_index", 32'(bus.out_index), 0);
`ifdef PSI_CARDINALITY_EN
    check("rst_card", 32'(card), 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick;

    // Directed patterns
    run_bitmap(10'b10_0010_0101, 0, '0, 1'b0);
    run_bitmap(10'h000, 0, '0, 1'b0);
    run_bitmap(10'h3FF, 1, '0, 1'b0);
    // Back-to-back with in_valid held high; 10'h200 presented during EMIT
    run_bitmap(10'h001, 0, 10'h200, 1'b1);
    run_bitmap(10'h200, 0, 10'h155, 1'b1);
    bus.in_valid = 1'b0;

    // Reset during the third beat of 10'h3FF
    bus.in_valid  = 1'b1;
    bus.in_bitmap = 10'h3FF;
    bus.out_ready = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    tick;
    check("pre_rst_index", 32'(bus.out_index), 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 1);
    check("mid_rst_out_last", 32'(bus.out_last), 1);
    check("mid_rst_out_empty", 32'(bus.out_empty), 1);
    check("mid_rst_out_index", 32'(bus.out_index), 0);
`ifdef PSI_CARDINALITY_EN
    check("mid_rst_card", 32'(card), 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_bitmap(10'h010, 0, '0, 1'b0);

    // Randomized bitmaps, ready patterns and ignored input activity
    for (int t = 0; t < 40; t++) begin
      rb  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      rnb = W'($urandom);
      run_bitmap(rb, 2, rnb, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
